hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter WAYS, default 3: issue width, i.e. the number of decode ways per bundle; legal range 1..8.
REQ-002 Parameter STAGES, default 2: number of tracked forwarding stages; stage 0 is EX/MEM and stage STAGES-1 is the oldest.
REQ-003 Parameter LOAD_READY, default 1: index of the first stage from which a load result can be forwarded; legal range 1..STAGES-1.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port id_valid, input, [WAYS]: decode way holds a real instruction.
REQ-007 Ports id_rs1 and id_rs2, input, [WAYS][5]: source register indices of each way.
REQ-008 Port id_dest, input, [WAYS][5]: destination register of each way; 0 means no write.
REQ-009 Port id_rd_mem, input, [WAYS]: the way is a load.
REQ-010 Port pipe_en, input, 1 bit: the pipeline advances this cycle.
REQ-011 Port flush, input, 1 bit: squash all in-flight entries.
REQ-012 Port rollback, output, $clog2(WAYS+1) bits: number of trailing ways rejected this cycle.
REQ-013 Ports fwd_a and fwd_b, output, [WAYS] of FWD_SRC: per-way operand forwarding source.
REQ-014 Port rollback_events, output, 32 bits: saturating count of advancing cycles in which rollback was nonzero.

Function
REQ-015 The tracking table SHALL hold STAGES x WAYS entries, each entry {valid, dest[5], is_load}.
REQ-016 rollback and fwd_a/fwd_b SHALL be combinational from the id_* inputs and the current table, with zero-cycle latency.
REQ-017 Operand match: an operand matches an entry when the entry is valid, entry.dest equals the operand index, and the operand index is nonzero. Invalid ways SHALL never match, never be matched, and never produce hazards.
REQ-018 Forwarding priority SHALL select the youngest producer: the lowest stage index wins; within a stage, the highest way wins. With no match, the output SHALL be {hit=0, stage=0, way=0}.
REQ-019 A way i has a hazard if either of the following holds:
- an operand matches a load entry in a stage with index below LOAD_READY;
- an operand equals the nonzero id_dest of a valid way k, with k<i.
REQ-020 rollback SHALL equal WAYS-i, where i is the lowest-indexed hazarding way; rollback SHALL be 0 when no way hazards. Ways i..WAYS-1 are rejected.
REQ-021 On a rising edge with pipe_en=1 and flush=0, the table SHALL shift:
- stage s+1 takes the contents of stage s;
- stage 0 takes the accepted ways (way index below WAYS-rollback, with id_valid=1);
- rejected ways are loaded as invalid entries.
REQ-022 With pipe_en=0 and flush=0, the table SHALL hold its contents; outputs continue to be evaluated against the held table.
REQ-023 When flush=1, all entries SHALL be invalid after the edge, regardless of pipe_en; the current bundle SHALL NOT enter the table.
REQ-024 rollback_events SHALL increment on an edge with pipe_en=1, flush=0 and rollback nonzero, and SHALL saturate at 32'hFFFF_FFFF. Flush SHALL NOT clear it.
REQ-025 When rollback=WAYS, stage 0 SHALL receive a full bubble and the older stages SHALL still advance, so a load-use stall resolves without deadlock.

Reset
REQ-026 While reset=0, all entries SHALL be invalid and rollback_events SHALL be 0, asynchronously. Consequently rollback=0 and all fwd outputs report no hit, unless intra-bundle hazards exist.
REQ-027 Reset deassertion mid-bundle SHALL take effect without glitching the table; the first update occurs on the first rising edge with reset=1.

Structure
REQ-028 Package sys_defs SHALL define:
- typedef FWD_SRC {hit, stage[$clog2(STAGES)], way[$clog2(WAYS)]};
- constant ZERO_REG;
- the defaults WAYS, STAGES and LOAD_READY.
REQ-029 A single sub-module fwd_source_select SHALL be instantiated 2 x WAYS times. Each instance takes one operand index and the table, and returns FWD_SRC plus a load-not-ready flag.

Verification
REQ-030 Reset held, then released with all id_valid=0 -> rollback=0, no fwd hit, rollback_events=0.
REQ-031 Cycle 1: way2 writes x5, pipe_en=1. Cycle 2: way0 reads rs1=x5 -> fwd_a[0]={1,0,2}, rollback=0. Cycle 3, pipe_en held 0 -> fwd_a[0] still {1,0,2}. Cycle 3 with pipe_en=1 instead -> fwd_a[0]={1,1,2}.
REQ-032 Way0 is a load writing x7. Next cycle way1 reads rs2=x7 -> rollback=2, rollback_events=1. Following cycle, with the load in stage 1 -> rollback=0, fwd_b[1]={1,1,0}.
REQ-033 Same bundle: way0 writes x3, way2 reads x3 -> rollback=1. Variant: way0 id_valid=0 -> rollback=0.
REQ-034 Operands x0 everywhere, with table entries having dest=0 -> no hit, rollback=0.
REQ-035 Flush asserted with a full table -> all entries invalid next cycle; rollback_events unchanged. Counter preset to 32'hFFFF_FFFF then a further rollback -> stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the issue-stage hazard scoreboard.
// FWD_SRC field widths follow the default WAYS/STAGES below.
package sys_defs;

    localparam int DEFAULT_WAYS       = 3;
    localparam int DEFAULT_STAGES     = 2;
    localparam int DEFAULT_LOAD_READY = 1;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int FWD_STAGE_W = (DEFAULT_STAGES > 1) ? $clog2(DEFAULT_STAGES) : 1;
    localparam int FWD_WAY_W   = (DEFAULT_WAYS > 1) ? $clog2(DEFAULT_WAYS) : 1;

    typedef struct packed {
        logic                   hit;
        logic [FWD_STAGE_W-1:0] stage;
        logic [FWD_WAY_W-1:0]   way;
    } FWD_SRC;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } tbl_entry_t;

    localparam FWD_SRC FWD_NONE = '0;

    // x0 is hardwired, so it can never be produced by an in-flight entry
    function automatic logic entry_match(input tbl_entry_t e, input logic [4:0] op);
        return e.valid && (e.dest == op) && (op != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd.sv
// Per-operand producer search over the in-flight table: picks the youngest
// matching producer and flags a match against a load that cannot forward yet.
module fwd_source_select
    import sys_defs::*;
#(
    parameter int WAYS       = DEFAULT_WAYS,
    parameter int STAGES     = DEFAULT_STAGES,
    parameter int LOAD_READY = DEFAULT_LOAD_READY
) (
    input  logic [4:0]                             op_idx_i,
    input  tbl_entry_t [STAGES-1:0][WAYS-1:0]      table_i,
    output FWD_SRC                                 src_o,
    output logic                                   load_not_ready_o
);

    logic match_s;

    // Scan oldest stage first and low way first so later hits overwrite: lowest stage, highest way wins
    always_comb begin
        src_o            = FWD_NONE;
        load_not_ready_o = 1'b0;
        match_s          = 1'b0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            for (int w = 0; w < WAYS; w++) begin
                match_s = entry_match(table_i[s][w], op_idx_i);
                src_o   = match_s ? FWD_SRC'{hit: 1'b1,
                                             stage: FWD_STAGE_W'(s),
                                             way: FWD_WAY_W'(w)} : src_o;
                load_not_ready_o = load_not_ready_o ||
                                   (match_s && table_i[s][w].is_load && (s < LOAD_READY));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight destinations, reports
// forwarding sources per operand and how many trailing ways must roll back.
module hazard_scoreboard
    import sys_defs::*;
#(
    parameter int WAYS       = DEFAULT_WAYS,
    parameter int STAGES     = DEFAULT_STAGES,
    parameter int LOAD_READY = DEFAULT_LOAD_READY
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WAYS-1:0]               id_valid,
    input  logic [WAYS-1:0][4:0]          id_rs1,
    input  logic [WAYS-1:0][4:0]          id_rs2,
    input  logic [WAYS-1:0][4:0]          id_dest,
    input  logic [WAYS-1:0]               id_rd_mem,
    input  logic                          pipe_en,
    input  logic                          flush,
    output logic [$clog2(WAYS+1)-1:0]     rollback,
    output FWD_SRC [WAYS-1:0]             fwd_a,
    output FWD_SRC [WAYS-1:0]             fwd_b,
    output logic [31:0]                   rollback_events
);

    localparam int RB_W = $clog2(WAYS + 1);

    tbl_entry_t [STAGES-1:0][WAYS-1:0] table_q;
    tbl_entry_t [STAGES-1:0][WAYS-1:0] table_d;
    logic [31:0]                       rollback_events_q;
    logic [31:0]                       rollback_events_d;

    logic [WAYS-1:0][4:0] op_a_s;
    logic [WAYS-1:0][4:0] op_b_s;
    logic [WAYS-1:0]      nr_a_s;
    logic [WAYS-1:0]      nr_b_s;
    logic [WAYS-1:0]      haz_s;
    logic [WAYS-1:0]      accept_s;
    logic                 blocked_s;
    logic [RB_W-1:0]      rollback_s;

    // Empty ways present x0 to the search so they can never hit the table
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            op_a_s[w] = id_valid[w] ? id_rs1[w] : ZERO_REG;
            op_b_s[w] = id_valid[w] ? id_rs2[w] : ZERO_REG;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        fwd_source_select #(
            .WAYS       (WAYS),
            .STAGES     (STAGES),
            .LOAD_READY (LOAD_READY)
        ) u_fwd_a (
            .op_idx_i         (op_a_s[w]),
            .table_i          (table_q),
            .src_o            (fwd_a[w]),
            .load_not_ready_o (nr_a_s[w])
        );

        fwd_source_select #(
            .WAYS       (WAYS),
            .STAGES     (STAGES),
            .LOAD_READY (LOAD_READY)
        ) u_fwd_b (
            .op_idx_i         (op_b_s[w]),
            .table_i          (table_q),
            .src_o            (fwd_b[w]),
            .load_not_ready_o (nr_b_s[w])
        );
    end

    // Per-way hazard: unready load in the table, or RAW on an older way of the same bundle
    always_comb begin
        haz_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            haz_s[w] = id_valid[w] & (nr_a_s[w] | nr_b_s[w]);
            for (int k = 0; k < w; k++) begin
                haz_s[w] = haz_s[w] |
                           (id_valid[w] & id_valid[k] & (id_dest[k] != ZERO_REG) &
                            ((id_rs1[w] == id_dest[k]) | (id_rs2[w] == id_dest[k])));
            end
        end
    end

    // The first hazarding way and everything after it are rejected
    always_comb begin
        rollback_s = '0;
        accept_s   = '0;
        blocked_s  = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            rollback_s = haz_s[w] ? RB_W'(WAYS - w) : rollback_s;
        end
        for (int w = 0; w < WAYS; w++) begin
            blocked_s   = blocked_s | haz_s[w];
            accept_s[w] = id_valid[w] & ~blocked_s;
        end
    end

    // Table shift/hold/flush and saturating rollback counter next state
    always_comb begin
        table_d           = table_q;
        rollback_events_d = rollback_events_q;
        if (flush) begin
            table_d = '0;
        end else if (pipe_en) begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                table_d[s] = table_q[s-1];
            end
            for (int w = 0; w < WAYS; w++) begin
                table_d[0][w].valid   = accept_s[w];
                table_d[0][w].dest    = accept_s[w] ? id_dest[w] : ZERO_REG;
                table_d[0][w].is_load = accept_s[w] & id_rd_mem[w];
            end
        end else begin
            table_d = table_q;
        end

        if (pipe_en && !flush && (rollback_s != '0) && (rollback_events_q != 32'hFFFF_FFFF)) begin
            rollback_events_d = rollback_events_q + 32'd1;
        end else begin
            rollback_events_d = rollback_events_q;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            table_q           <= '0;
            rollback_events_q <= '0;
        end else begin
            table_q           <= table_d;
            rollback_events_q <= rollback_events_d;
        end
    end

    assign rollback        = rollback_s;
    assign rollback_events = rollback_events_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard with a queue-based
// in-flight model and a decoupled scoreboard monitor.
module tb_hazard_scoreboard;
    import sys_defs::*;

    localparam int WAYS       = DEFAULT_WAYS;
    localparam int STAGES     = DEFAULT_STAGES;
    localparam int LOAD_READY = DEFAULT_LOAD_READY;
    localparam int RB_W       = $clog2(WAYS + 1);

    logic                 clock = 1'b0;
    logic                 reset;
    logic [WAYS-1:0]      id_valid;
    logic [WAYS-1:0][4:0] id_rs1;
    logic [WAYS-1:0][4:0] id_rs2;
    logic [WAYS-1:0][4:0] id_dest;
    logic [WAYS-1:0]      id_rd_mem;
    logic                 pipe_en;
    logic                 flush;
    logic [RB_W-1:0]      rollback;
    FWD_SRC [WAYS-1:0]    fwd_a;
    FWD_SRC [WAYS-1:0]    fwd_b;
    logic [31:0]          rollback_events;

    hazard_scoreboard #(
        .WAYS(WAYS), .STAGES(STAGES), .LOAD_READY(LOAD_READY)
    ) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_dest(id_dest), .id_rd_mem(id_rd_mem),
        .pipe_en(pipe_en), .flush(flush), .rollback(rollback),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .rollback_events(rollback_events)
    );

    always #5 clock = ~clock;

    // In-flight instruction: how far it has travelled, which way it issued from
    typedef struct {
        int         stage;
        int         way;
        logic [4:0] dest;
        logic       ld;
    } rec_t;

    typedef struct {
        logic [RB_W-1:0] rb;
        FWD_SRC          fa [WAYS];
        FWD_SRC          fb [WAYS];
        logic [31:0]     ev;
    } exp_t;

    rec_t        infl[$];
    exp_t        expq[$];
    logic [31:0] mdl_events;
    logic [31:0] preset_val;
    int          checks;
    int          errors;

    logic [WAYS-1:0]      rv;
    logic [WAYS-1:0]      rld;
    logic [WAYS-1:0][4:0] rr1;
    logic [WAYS-1:0][4:0] rr2;
    logic [WAYS-1:0][4:0] rd;

    function automatic logic [WAYS-1:0][4:0] regs(input logic [4:0] a0, input logic [4:0] a1,
                                                  input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    // Youngest producer: smallest age, then highest way
    function automatic FWD_SRC lookup(input logic [4:0] op);
        FWD_SRC r;
        int     bs;
        int     bw;
        r  = '0;
        bs = STAGES;
        bw = -1;
        if (op != 5'd0) begin
            foreach (infl[j]) begin
                if (infl[j].dest == op &&
                    (infl[j].stage < bs || (infl[j].stage == bs && infl[j].way > bw))) begin
                    bs = infl[j].stage;
                    bw = infl[j].way;
                end
            end
        end
        if (bw >= 0) begin
            r.hit   = 1'b1;
            r.stage = FWD_STAGE_W'(bs);
            r.way   = FWD_WAY_W'(bw);
        end
        return r;
    endfunction

    function automatic logic unready(input logic [4:0] op);
        logic u;
        u = 1'b0;
        foreach (infl[j]) begin
            if (op != 5'd0 && infl[j].dest == op && infl[j].ld && infl[j].stage < LOAD_READY)
                u = 1'b1;
        end
        return u;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle, push its expected outputs, then advance the model past the edge
    task automatic step(input logic [WAYS-1:0] v, input logic [WAYS-1:0][4:0] r1,
                        input logic [WAYS-1:0][4:0] r2, input logic [WAYS-1:0][4:0] d,
                        input logic [WAYS-1:0] ld, input logic pe, input logic fl,
                        input logic rs, input logic pre);
        exp_t       e;
        int         first;
        logic       haz;
        logic [4:0] oa;
        logic [4:0] ob;
        rec_t       nq[$];
        @(negedge clock);
        if (pre) begin
            force dut.rollback_events_q = preset_val;
            #1;
            release dut.rollback_events_q;
            mdl_events = preset_val;
        end
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_dest = d; id_rd_mem = ld;
        pipe_en = pe; flush = fl; reset = rs;
        if (!rs) begin
            infl.delete();
            mdl_events = 32'd0;
        end
        first = WAYS;
        for (int w = WAYS - 1; w >= 0; w--) begin
            oa = v[w] ? r1[w] : 5'd0;
            ob = v[w] ? r2[w] : 5'd0;
            e.fa[w] = lookup(oa);
            e.fb[w] = lookup(ob);
            haz = v[w] && (unready(oa) || unready(ob));
            for (int k = 0; k < w; k++) begin
                if (v[w] && v[k] && d[k] != 5'd0 && (r1[w] == d[k] || r2[w] == d[k])) haz = 1'b1;
            end
            if (haz) first = w;
        end
        e.rb = RB_W'(WAYS - first);
        e.ev = mdl_events;
        expq.push_back(e);
        if (rs && fl) begin
            infl.delete();
        end else if (rs && pe) begin
            foreach (infl[j]) begin
                rec_t r;
                r = infl[j];
                r.stage = r.stage + 1;
                if (r.stage < STAGES) nq.push_back(r);
            end
            for (int w = 0; w < first; w++) begin
                if (v[w]) nq.push_back('{stage: 0, way: w, dest: d[w], ld: ld[w]});
            end
            infl = nq;
            if (first < WAYS && mdl_events != 32'hFFFF_FFFF) mdl_events = mdl_events + 32'd1;
        end
    endtask

    // Scoreboard monitor: the outputs are valid every cycle, sampled mid low phase
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rollback", 32'(rollback), 32'(e.rb));
                for (int w = 0; w < WAYS; w++) begin
                    chk($sformatf("fwd_a[%0d]", w), 32'(fwd_a[w]), 32'(e.fa[w]));
                    chk($sformatf("fwd_b[%0d]", w), 32'(fwd_b[w]), 32'(e.fb[w]));
                end
                chk("rollback_events", rollback_events, e.ev);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; mdl_events = 32'd0; preset_val = 32'd0;
        reset = 1'b0; id_valid = '0; id_rs1 = '0; id_rs2 = '0; id_dest = '0;
        id_rd_mem = '0; pipe_en = 1'b0; flush = 1'b0;

        // Reset held, idle and with an intra-bundle RAW; then released idle
        step(3'b000, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'b011, regs(0,4,0), regs(0,0,0), regs(4,0,0), 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'b000, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Forwarding from way2, held table, then one stage older
        step(3'b100, regs(0,0,0), regs(0,0,0), regs(0,0,5), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b001, regs(5,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b001, regs(5,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b001, regs(5,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b001, regs(5,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Load-use stall resolves one cycle later
        step(3'b000, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
        step(3'b001, regs(0,0,0), regs(0,0,0), regs(7,0,0), 3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b010, regs(0,0,0), regs(0,7,0), regs(0,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b010, regs(0,0,0), regs(0,7,0), regs(0,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Intra-bundle RAW and its invalid-producer variant
        step(3'b101, regs(0,0,3), regs(0,0,0), regs(3,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b100, regs(0,0,3), regs(0,0,0), regs(3,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // x0 operands against x0 destinations
        step(3'b111, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b111, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Fill the table, flush it, confirm nothing forwards and the counter is kept
        step(3'b111, regs(0,0,0), regs(0,0,0), regs(9,10,11), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b111, regs(0,0,0), regs(0,0,0), regs(12,13,14), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b111, regs(9,10,11), regs(12,13,14), regs(0,0,0), 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
        step(3'b111, regs(9,10,11), regs(12,13,14), regs(0,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Counter saturation
        preset_val = 32'hFFFF_FFFE;
        step(3'b011, regs(0,6,0), regs(0,0,0), regs(6,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
        step(3'b011, regs(0,6,0), regs(0,0,0), regs(6,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b011, regs(0,6,0), regs(0,0,0), regs(6,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        preset_val = 32'hFFFF_FFFF;
        step(3'b011, regs(0,6,0), regs(0,0,0), regs(6,0,0), 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
        step(3'b011, regs(0,6,0), regs(0,0,0), regs(6,0,0), 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
        step(3'b000, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic over a small register window to force frequent matches
        for (int n = 0; n < 400; n++) begin
            rv  = WAYS'($urandom);
            rld = WAYS'($urandom);
            for (int w = 0; w < WAYS; w++) begin
                rr1[w] = 5'($urandom_range(0, 6));
                rr2[w] = 5'($urandom_range(0, 6));
                rd[w]  = 5'($urandom_range(0, 6));
            end
            step(rv, rr1, rr2, rd, rld, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0), 1'b0);
        end

        step(3'b000, regs(0,0,0), regs(0,0,0), regs(0,0,0), 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        chk("scoreboard_drain", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
